uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single memory-mapped UART transmitter between NumReq byte-stream requesters, for example a core console and a debug/trace source.
- Acts as a bus master on the UART device port. Before every TX write it polls the UART status register and only writes when the TX FIFO is not full.
- Arbitration is round-robin at line granularity. Once a requester has sent a byte it keeps ownership until it sends NewlineChar, so lines from different requesters never interleave.

Parameters:
- NumReq, 2, number of requesters (2..8).
- UartBase, 32'h0, base address of the UART: TX register at UartBase+0, status register at UartBase+4.
- NewlineChar, 8'h0A, byte that releases the line lock.
- LockTimeout, 1024, idle cycles before a stalled lock is released (used only with the optional feature).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i  in  NumReq  requester i has a byte
- req_data_i  in  NumReq*8  byte of requester i, at bits [8i+7:8i]
- req_ready_o  out  NumReq  one-cycle pulse: byte of requester i accepted
- owner_o  out  $clog2(NumReq) (min 1)  current or last granted requester
- locked_o  out  1  a line lock is held
- busy_o  out  1  FSM not in IDLE
- device_req_o  out  1  bus request to UART
- device_addr_o  out  32  bus address
- device_we_o  out  1  write enable
- device_be_o  out  4  byte enables, always 4'b0001 when device_req_o=1
- device_wdata_o  out  32  {24'b0, byte}
- device_rvalid_i  in  1  UART response, one cycle after each request
- device_rdata_i  in  32  bit 0 = TX FIFO full on status reads

Behaviour:
- Reset values: all outputs 0; internal state IDLE, lock 0, last_grant = NumReq-1 so requester 0 wins first.
- IDLE:
  - If unlocked, the winner is the first valid requester searching from last_grant+1 with wrap-around.
  - If locked, only owner_o is eligible; other requesters stall.
  - On a winner: pulse req_ready_o[winner] for one cycle, capture the byte into byte_q, set owner_o=winner, go to POLL.
- POLL: device_req_o=1, we=0, addr=UartBase+4, for exactly one cycle, then go to WAIT_STATUS.
- WAIT_STATUS:
  - Wait for device_rvalid_i.
  - If device_rdata_i[0]=1, go back to POLL. There is no retry limit.
  - Otherwise go to WRITE.
- WRITE: device_req_o=1, we=1, addr=UartBase+0, wdata={24'b0, byte_q}, for one cycle, then go to WAIT_ACK.
- WAIT_ACK: wait for device_rvalid_i, then go to IDLE.
  - If byte_q==NewlineChar: lock=0, last_grant=owner_o.
  - Otherwise: lock=1.
- Minimum latency is 5 cycles per byte (accept to next IDLE). Full-FIFO retries add 2 cycles each.
- device_rvalid_i outside the WAIT states is ignored. device_rdata_i is sampled only in WAIT_STATUS.
- A requester may drop valid before ready without error. Its data must be stable only in the cycle ready is pulsed.
- If the owner's valid is low while locked, the FSM stays in IDLE (without the optional feature).
- Reset mid-transfer returns the FSM to IDLE immediately and clears the lock. The in-flight byte is lost; it was already acknowledged to the requester.
- device_addr_o, device_we_o and device_wdata_o are 0 whenever device_req_o=0.

Optional Feature:
- Macro: UART_TX_ARB_LOCK_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(LockTimeout+1) increments each cycle in IDLE while locked and req_valid_i[owner_o]=0.
  - The counter clears on any grant or unlock.
  - When it reaches LockTimeout: lock=0, last_grant=owner_o, so arbitration resumes next cycle.
- Undefined: no counter exists, and a lock persists until NewlineChar is sent.

Test Plan:
- Single requester: req0 valid with 0x41, status replies 0 -> one read at 0x4, then one write at 0x0 with wdata 0x00000041. req_ready_o[0] pulses once. Back in IDLE 5 cycles after accept.
- Interleave: req0 sends "AB\n", req1 sends "xy\n", both valid from reset -> write sequence 41,42,0A,78,79,0A. locked_o=1 between 41 and 0A.
- Backpressure: status full=1 on 3 consecutive polls, then 0 -> 4 status reads, then 1 write. req_ready_o pulses only once.
- Fairness: both requesters continuously send 0x0A -> grants alternate 0,1,0,1 over 8 bytes.
- Reset: assert rst_ni low during WAIT_ACK -> all outputs 0 that cycle. After release, requester 0 wins first.
- Timeout, LockTimeout=16: req0 sends 'A' then idles, req1 valid. With the macro defined, req1 is granted 17 cycles after req0's WAIT_ACK. Without the macro, req1 is never granted.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// Shares one memory-mapped UART transmitter between NumReq byte-stream
// requesters. Each accepted byte is sent as: poll status register until the
// TX FIFO is not full, then write the byte to the TX register. Arbitration is
// round-robin per line: once a requester sends a byte it owns the UART until
// it sends NewlineChar, so lines from different requesters never interleave.
//
// Optional build macro: UART_TX_ARB_LOCK_TIMEOUT_EN
//   When defined, a lock whose owner stays idle for LockTimeout cycles is
//   released so the other requesters can continue.
//
// Handshake: req_valid_i[i]/req_ready_o[i] follow valid/ready semantics where
//   ready is a one-cycle acceptance pulse; the byte on req_data_i is captured
//   in the cycle ready is high. Valid may be dropped before ready.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   req_valid_i[NumReq]   requester i has a byte
//   req_data_i[8*NumReq]  byte of requester i at bits [8i+7:8i]
//   req_ready_o[NumReq]   byte of requester i accepted (one-cycle pulse)
//   owner_o               current or last granted requester
//   locked_o              a line lock is held
//   busy_o                FSM not in IDLE
//   device_*              bus master port to the UART (response one cycle
//                         after each request; rdata bit 0 = TX FIFO full)

module uart_tx_arbiter #(
    parameter int unsigned NumReq      = 2,
    parameter logic [31:0] UartBase    = 32'h0,
    parameter logic [7:0]  NewlineChar = 8'h0A,
    parameter int unsigned LockTimeout = 1024,
    localparam int unsigned OwnW       = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NumReq-1:0]     req_valid_i,
    input  logic [NumReq*8-1:0]   req_data_i,
    output logic [NumReq-1:0]     req_ready_o,
    output logic [OwnW-1:0]       owner_o,
    output logic                  locked_o,
    output logic                  busy_o,
    output logic                  device_req_o,
    output logic [31:0]           device_addr_o,
    output logic                  device_we_o,
    output logic [3:0]            device_be_o,
    output logic [31:0]           device_wdata_o,
    input  logic                  device_rvalid_i,
    input  logic [31:0]           device_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POLL,
        S_WAIT_STATUS,
        S_WRITE,
        S_WAIT_ACK
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      byte_q;
    logic [OwnW-1:0] owner_q;
    logic [OwnW-1:0] last_q;
    logic            lock_q;

    logic [OwnW-1:0] win_idx;
    logic [OwnW-1:0] cand;
    logic            win_found;
    logic            grant;
    logic            timeout_hit;
    logic [7:0]      req_bytes [NumReq];

    for (genvar g = 0; g < NumReq; g++) begin : g_bytes
        assign req_bytes[g] = req_data_i[8*g +: 8];
    end

    // Round-robin search starting after last_q. last_q only moves when a
    // line completes, so a requester that keeps its lock cannot starve others
    // beyond one line.
    always_comb begin : arbitrate
        win_found = 1'b0;
        win_idx   = '0;
        cand      = last_q;
        if (lock_q) begin
            win_found = req_valid_i[owner_q];
            win_idx   = owner_q;
        end else begin
            for (int unsigned k = 0; k < NumReq; k++) begin
                cand = (cand == OwnW'(NumReq - 1)) ? '0 : cand + OwnW'(1);
                if (!win_found && req_valid_i[cand]) begin
                    win_found = 1'b1;
                    win_idx   = cand;
                end
            end
        end
    end

    // Grant is gated by rst_ni so no acceptance pulse escapes during reset.
    assign grant = rst_ni && (state_q == S_IDLE) && win_found;

    always_comb begin : fsm
        state_d        = state_q;
        req_ready_o    = '0;
        device_req_o   = 1'b0;
        device_we_o    = 1'b0;
        device_addr_o  = '0;
        device_be_o    = '0;
        device_wdata_o = '0;
        unique case (state_q)
            S_IDLE: begin
                if (grant) begin
                    req_ready_o[win_idx] = 1'b1;
                    state_d              = S_POLL;
                end
            end
            S_POLL: begin
                device_req_o  = 1'b1;
                device_addr_o = UartBase + 32'd4;
                device_be_o   = 4'b0001;
                state_d       = S_WAIT_STATUS;
            end
            S_WAIT_STATUS: begin
                if (device_rvalid_i) begin
                    state_d = device_rdata_i[0] ? S_POLL : S_WRITE;
                end
            end
            S_WRITE: begin
                device_req_o   = 1'b1;
                device_we_o    = 1'b1;
                device_addr_o  = UartBase;
                device_be_o    = 4'b0001;
                device_wdata_o = {24'b0, byte_q};
                state_d        = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (device_rvalid_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            byte_q  <= '0;
            owner_q <= '0;
            lock_q  <= 1'b0;
            last_q  <= OwnW'(NumReq - 1);
        end else begin
            state_q <= state_d;
            if (grant) begin
                byte_q  <= req_bytes[win_idx];
                owner_q <= win_idx;
            end
            if ((state_q == S_WAIT_ACK) && device_rvalid_i) begin
                if (byte_q == NewlineChar) begin
                    lock_q <= 1'b0;
                    last_q <= owner_q;
                end else begin
                    lock_q <= 1'b1;
                end
            end else if (timeout_hit) begin
                lock_q <= 1'b0;
                last_q <= owner_q;
            end
        end
    end

`ifdef UART_TX_ARB_LOCK_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(LockTimeout + 1);

    logic [CntW-1:0] idle_cnt_q;
    logic            stall;

    // The unlock fires on the edge where the count reaches LockTimeout, so
    // arbitration resumes in the very next IDLE cycle.
    assign stall       = (state_q == S_IDLE) && lock_q && !req_valid_i[owner_q];
    assign timeout_hit = stall && (idle_cnt_q == CntW'(LockTimeout - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idle_cnt_q <= '0;
        end else if (!stall || timeout_hit) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_q + CntW'(1);
        end
    end
`else
    localparam int unsigned UnusedLockTimeout = LockTimeout;
    assign timeout_hit = 1'b0;
`endif

    // Only the FIFO-full flag of the status word carries meaning.
    logic unused_rdata;
    assign unused_rdata = ^device_rdata_i[31:1];

    assign owner_o  = owner_q;
    assign locked_o = lock_q;
    assign busy_o   = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int          NUM_REQ   = 3;
    localparam int          OWN_W     = 2;
    localparam int          REQ_W     = NUM_REQ * 8;
    localparam logic [31:0] UART_BASE = 32'h0;
    localparam logic [7:0]  NL        = 8'h0A;
    localparam int          LOCK_TO   = 16;

    // ---------------- clock / reset / DUT ----------------
    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic [NUM_REQ-1:0] req_valid_i;
    logic [REQ_W-1:0]   req_data_i;
    logic [NUM_REQ-1:0] req_ready_o;
    logic [OWN_W-1:0]   owner_o;
    logic               locked_o;
    logic               busy_o;
    logic               device_req_o;
    logic [31:0]        device_addr_o;
    logic               device_we_o;
    logic [3:0]         device_be_o;
    logic [31:0]        device_wdata_o;
    logic               device_rvalid_i;
    logic [31:0]        device_rdata_i;

    always #5 clk_i = ~clk_i;

    uart_tx_arbiter #(
        .NumReq      (NUM_REQ),
        .UartBase    (UART_BASE),
        .NewlineChar (NL),
        .LockTimeout (LOCK_TO)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .req_valid_i     (req_valid_i),
        .req_data_i      (req_data_i),
        .req_ready_o     (req_ready_o),
        .owner_o         (owner_o),
        .locked_o        (locked_o),
        .busy_o          (busy_o),
        .device_req_o    (device_req_o),
        .device_addr_o   (device_addr_o),
        .device_we_o     (device_we_o),
        .device_be_o     (device_be_o),
        .device_wdata_o  (device_wdata_o),
        .device_rvalid_i (device_rvalid_i),
        .device_rdata_i  (device_rdata_i)
    );

    // ---------------- bench state ----------------
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] src_q [NUM_REQ][$];   // bytes each requester still has to offer
    logic [7:0] m_q   [NUM_REQ][$];   // reference model's view of the same
    logic [7:0] exp_q [$];            // scoreboard: expected TX write bytes
    int         exp_own [$];
    logic       exp_lock [$];
    logic       full_q [$];           // scripted FIFO-full replies
    logic [7:0] wr_log [$];
    int         grant_log [$];
    int         n_grant [NUM_REQ];
    int         first_grant_cyc [NUM_REQ];
    int         cyc, acc_cyc, retries, cur_owner, n_reads, n_writes;
    int         m_last, m_owner;
    bit         m_lock, pend, pend_status, in_flight, rand_full, spurious;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Line-granular round robin over byte queues: an unlocked arbiter picks the
    // first requester with data after the last line owner; a non-newline byte
    // locks the owner, a newline releases it.
    task automatic model_run();
        int         pick;
        logic [7:0] b;
        while (1) begin
            pick = -1;
            if (m_lock) begin
                if (m_q[m_owner].size() > 0) pick = m_owner;
            end else begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    int c;
                    c = (m_last + k) % NUM_REQ;
                    if (pick < 0 && m_q[c].size() > 0) pick = c;
                end
            end
            if (pick < 0) break;
            b = m_q[pick].pop_front();
            exp_q.push_back(b);
            exp_own.push_back(pick);
            exp_lock.push_back(m_lock);
            m_owner = pick;
            if (b == NL) begin
                m_lock = 1'b0;
                m_last = pick;
            end else begin
                m_lock = 1'b1;
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic load(input int r, input logic [7:0] b);
        src_q[r].push_back(b);
        m_q[r].push_back(b);
    endtask

    task automatic drive_reqs();
        for (int r = 0; r < NUM_REQ; r++) begin
            if (src_q[r].size() > 0) begin
                req_valid_i[r]         = 1'b1;
                req_data_i[8*r +: 8]   = src_q[r][0];
            end else begin
                req_valid_i[r]         = 1'b0;
                req_data_i[8*r +: 8]   = 8'($urandom());
            end
        end
    endtask

    function automatic logic next_full();
        if (full_q.size() > 0) return full_q.pop_front();
        if (rand_full) return ($urandom_range(0, 3) == 0);
        return 1'b0;
    endfunction

    // One clock: observe at the negedge, then update inputs 1 time unit
    // after the posedge.
    task automatic step();
        logic [NUM_REQ-1:0] acc;
        logic [7:0]         eb;
        int                 eo;
        logic               el;
        logic               full;
        @(negedge clk_i);
        acc = req_ready_o;
        if (in_flight && !busy_o && cyc > acc_cyc) begin
            check("latency", 32'(cyc - acc_cyc), 32'(5 + 2 * retries));
            in_flight = 1'b0;
        end
        if (device_req_o) begin
            check("be", 32'(device_be_o), 32'h1);
            if (device_we_o) begin
                check("wr_addr", device_addr_o, UART_BASE);
                check("owner_o", 32'(owner_o), 32'(cur_owner));
                wr_log.push_back(device_wdata_o[7:0]);
                if (exp_q.size() == 0) begin
                    check("wr_unexpected", device_wdata_o, 32'hFFFF_FFFF);
                end else begin
                    eb = exp_q.pop_front();
                    check("wr_data", device_wdata_o, {24'b0, eb});
                end
                n_writes++;
            end else begin
                check("rd_addr", device_addr_o, UART_BASE + 32'd4);
                n_reads++;
            end
            pend        = 1'b1;
            pend_status = !device_we_o;
        end else begin
            check("bus_quiet", device_addr_o | device_wdata_o | 32'(device_we_o), 32'h0);
        end
        if (acc != '0) begin
            check("ready_onehot", 32'($countones(acc)), 32'h1);
            for (int r = 0; r < NUM_REQ; r++) begin
                if (acc[r]) begin
                    n_grant[r]++;
                    if (first_grant_cyc[r] < 0) first_grant_cyc[r] = cyc;
                    grant_log.push_back(r);
                    cur_owner = r;
                    if (exp_own.size() == 0) begin
                        check("grant_unexpected", 32'(r), 32'hFFFF_FFFF);
                    end else begin
                        eo = exp_own.pop_front();
                        el = exp_lock.pop_front();
                        check("grant_owner", 32'(r), 32'(eo));
                        check("lock_at_grant", 32'(locked_o), 32'(el));
                    end
                end
            end
            in_flight = 1'b1;
            acc_cyc   = cyc;
            retries   = 0;
        end
        @(posedge clk_i);
        #1;
        cyc++;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (acc[r] && src_q[r].size() > 0) void'(src_q[r].pop_front());
        end
        if (pend) begin
            device_rvalid_i = 1'b1;
            if (pend_status) begin
                full = next_full();
                if (full) retries++;
                device_rdata_i = {$urandom_range(0, 32'h7FFF_FFFF), full};
                device_rdata_i[31] = 1'b0;
            end else begin
                device_rdata_i = $urandom();
            end
            pend = 1'b0;
        end else begin
            // Stray responses land only in IDLE/POLL/WRITE and must be ignored.
            device_rvalid_i = spurious && ($urandom_range(0, 3) == 0);
            device_rdata_i  = $urandom();
        end
        drive_reqs();
    endtask

    task automatic run_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || in_flight) && n < budget) begin
            step();
            n++;
        end
        check("drain_left", 32'(exp_q.size()), 32'h0);
        repeat (2) step();
    endtask

    // Reset with all inputs active so any leaking output shows up.
    task automatic do_reset();
        rst_ni          = 1'b0;
        req_valid_i     = '1;
        req_data_i      = REQ_W'($urandom());
        device_rvalid_i = 1'b1;
        device_rdata_i  = $urandom();
        #1;
        check("rst_ready", 32'(req_ready_o), 32'h0);
        check("rst_ctrl", 32'({owner_o, locked_o, busy_o, device_req_o, device_we_o, device_be_o}), 32'h0);
        check("rst_addr", device_addr_o, 32'h0);
        check("rst_wdata", device_wdata_o, 32'h0);
        for (int r = 0; r < NUM_REQ; r++) begin
            src_q[r].delete();
            m_q[r].delete();
            n_grant[r]         = 0;
            first_grant_cyc[r] = -1;
        end
        exp_q.delete(); exp_own.delete(); exp_lock.delete();
        full_q.delete(); wr_log.delete(); grant_log.delete();
        pend = 0; in_flight = 0; retries = 0; n_reads = 0; n_writes = 0;
        m_last = NUM_REQ - 1; m_lock = 0; m_owner = 0;
        device_rvalid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        drive_reqs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- tests ----------------
    initial begin
        logic [7:0] il_exp [6];
        int         n;
        int         len;
        logic [7:0] b;
        il_exp = '{8'h41, 8'h42, 8'h0A, 8'h78, 8'h79, 8'h0A};
        cyc = 0; rand_full = 0; spurious = 0; cur_owner = 0; acc_cyc = 0;

        // Single requester
        do_reset();
        load(0, 8'h41); model_run(); drive_reqs();
        run_drain(60);
        check("single_reads", 32'(n_reads), 32'd1);
        check("single_writes", 32'(n_writes), 32'd1);
        check("single_ready", 32'(n_grant[0]), 32'd1);

        // Two lines, both valid from reset: no interleaving
        do_reset();
        load(0, 8'h41); load(0, 8'h42); load(0, NL);
        load(1, 8'h78); load(1, 8'h79); load(1, NL);
        model_run(); drive_reqs();
        run_drain(200);
        check("il_count", 32'(wr_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < wr_log.size(); i++) check("il_byte", 32'(wr_log[i]), 32'(il_exp[i]));

        // Backpressure: three full polls then free
        do_reset();
        full_q = '{1'b1, 1'b1, 1'b1};
        load(0, 8'h55); model_run(); drive_reqs();
        run_drain(100);
        check("bp_reads", 32'(n_reads), 32'd4);
        check("bp_writes", 32'(n_writes), 32'd1);
        check("bp_ready", 32'(n_grant[0]), 32'd1);

        // Fairness: newline-only streams alternate
        do_reset();
        for (int i = 0; i < 4; i++) begin load(0, NL); load(1, NL); end
        model_run(); drive_reqs();
        run_drain(300);
        check("fair_count", 32'(grant_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++) check("fair_order", 32'(grant_log[i]), 32'(i % 2));

        // Random lines, random FIFO-full replies, stray responses
        rand_full = 1; spurious = 1;
        for (int round = 0; round < 6; round++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if ($urandom_range(0, 1) == 1) begin
                    n = $urandom_range(1, 2);
                    for (int l = 0; l < n; l++) begin
                        len = $urandom_range(0, 3);
                        for (int j = 0; j < len; j++) begin
                            b = 8'($urandom());
                            if (b == NL) b = 8'h20;
                            load(r, b);
                        end
                        load(r, NL);
                    end
                end
            end
            model_run(); drive_reqs();
            run_drain(2000);
            check("rand_locked", 32'(locked_o), 32'h0);
        end
        rand_full = 0; spurious = 0;

        // Lock timeout: owner sends 'A' then goes quiet
        do_reset();
        load(0, 8'h41); load(1, 8'h78); load(1, NL);
        model_run();
`ifdef UART_TX_ARB_LOCK_TIMEOUT_EN
        m_lock = 1'b0; m_last = 0;
        model_run();
        drive_reqs();
        run_drain(300);
        // accept + 4 cycles reaches WAIT_ACK; the grant comes 17 cycles later
        check("to_grant_delay", 32'(first_grant_cyc[1] - first_grant_cyc[0]), 32'd21);
        check("to_req1_bytes", 32'(n_grant[1]), 32'd2);
`else
        drive_reqs();
        repeat (80) step();
        check("to_no_grant", 32'(n_grant[1]), 32'd0);
        check("to_locked", 32'(locked_o), 32'h1);
        check("to_writes", 32'(n_writes), 32'd1);
        load(0, NL); model_run(); drive_reqs();
        run_drain(300);
        check("to_req1_after_nl", 32'(n_grant[1]), 32'd2);
`endif

        // Reset in WAIT_ACK
        do_reset();
        load(0, 8'h41); load(0, NL); load(1, 8'h78); load(1, NL);
        model_run(); drive_reqs();
        n = 0;
        while (n_grant[0] == 0 && n < 20) begin step(); n++; end
        check("mid_accept", 32'(n_grant[0]), 32'd1);
        repeat (3) step();
        check("mid_busy", 32'({busy_o, device_req_o}), 32'h2);
        do_reset();
        load(1, 8'h78); load(1, NL); load(0, 8'h41); load(0, NL);
        model_run(); drive_reqs();
        run_drain(300);
        check("post_rst_grants", 32'(grant_log.size()), 32'd4);
        if (grant_log.size() > 0) check("post_rst_first", 32'(grant_log[0]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
